// File: rtl/coupling_prog_ctrl.sv
// Coupling-weight programming sequencer: streams a batch of column-bus writes, lets the array settle, then runs it.
// Define COUPLING_READBACK_EN to add a VERIFY readback cycle after each write with sticky mismatch reporting.
module coupling_prog_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             axi_rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      run_len,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_s_addr,
    input  logic [15:0]      cmd_d_addr,
    input  logic [31:0]      cmd_wdata,
    input  logic             cmd_last,
    output logic             wready,
    output logic             wr_match,
    output logic [15:0]      s_addr,
    output logic [15:0]      d_addr,
    output logic [31:0]      wdata,
    input  logic [31:0]      rdata,
    output logic             ising_rstn,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {
        IDLE, LOAD, WRITE, VERIFY, SETTLE, RUN, DONE
    } state_t;

    localparam logic [31:0] SETTLE_INIT = 32'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] run_len_q, run_len_d;
    logic [15:0] s_addr_q, s_addr_d;
    logic [15:0] d_addr_q, d_addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        last_q, last_d;
`ifdef COUPLING_READBACK_EN
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_len_d = run_len_q;
        s_addr_d  = s_addr_q;
        d_addr_d  = d_addr_q;
        wdata_d   = wdata_q;
        last_d    = last_q;
`ifdef COUPLING_READBACK_EN
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = LOAD;
                    run_len_d = run_len;
`ifdef COUPLING_READBACK_EN
                    err_d     = 1'b0;
                    err_cnt_d = '0;
`endif
                end
            end
            LOAD: begin
                if (cmd_valid) begin
                    state_d  = WRITE;
                    s_addr_d = cmd_s_addr;
                    d_addr_d = cmd_d_addr;
                    wdata_d  = cmd_wdata;
                    last_d   = cmd_last;
                end
            end
            WRITE: begin
`ifdef COUPLING_READBACK_EN
                state_d = VERIFY;
`else
                if (last_q) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_INIT;
                end else begin
                    state_d = LOAD;
                end
`endif
            end
`ifdef COUPLING_READBACK_EN
            VERIFY: begin
                // Mismatches are recorded but never stall the batch.
                if (rdata != wdata_q) begin
                    err_d = 1'b1;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                end
                if (last_q) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_INIT;
                end else begin
                    state_d = LOAD;
                end
            end
`endif
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                    // run_len of zero still gives one RUN cycle
                    cnt_d   = (run_len_q == '0) ? '0 : run_len_q - 32'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            RUN: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 32'd1;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (axi_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            run_len_q <= '0;
            s_addr_q  <= '0;
            d_addr_q  <= '0;
            wdata_q   <= '0;
            last_q    <= 1'b0;
`ifdef COUPLING_READBACK_EN
            err_q     <= 1'b0;
            err_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_len_q <= run_len_d;
            s_addr_q  <= s_addr_d;
            d_addr_q  <= d_addr_d;
            wdata_q   <= wdata_d;
            last_q    <= last_d;
`ifdef COUPLING_READBACK_EN
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    // Strobes are gated by reset so nothing leaks out while reset is held.
    assign cmd_ready  = !axi_rst && (state_q == LOAD);
    assign wready     = !axi_rst && (state_q == WRITE);
    assign wr_match   = !axi_rst && (state_q == WRITE || state_q == VERIFY);
    assign ising_rstn = !axi_rst && (state_q == RUN || state_q == DONE);
    assign busy       = !axi_rst && (state_q != IDLE && state_q != DONE);
    assign done       = !axi_rst && (state_q == DONE);
    assign s_addr     = s_addr_q;
    assign d_addr     = d_addr_q;
    assign wdata      = wdata_q;

`ifdef COUPLING_READBACK_EN
    assign err       = err_q;
    assign err_count = err_cnt_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^rdata;
    assign err          = 1'b0;
    assign err_count    = '0;
`endif

endmodule

// File: tb/tb_coupling_prog_ctrl.sv
// Randomized scoreboard bench for coupling_prog_ctrl; expectations come from a batch-level model of the sequencer.
module tb_coupling_prog_ctrl;

    localparam int SETTLE = 16;
    localparam int EW     = 8;
    localparam int EMAX   = (1 << EW) - 1;
`ifdef COUPLING_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          axi_rst, start, abort, cmd_valid, cmd_last;
    logic [31:0]   run_len, cmd_wdata, rdata, wdata;
    logic [15:0]   cmd_s_addr, cmd_d_addr, s_addr, d_addr;
    logic          cmd_ready, wready, wr_match, ising_rstn, busy, done, err;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    coupling_prog_ctrl #(.SETTLE_CYCLES(SETTLE), .ERR_W(EW)) dut (
        .clk(clk), .axi_rst(axi_rst), .start(start), .abort(abort), .run_len(run_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_s_addr(cmd_s_addr),
        .cmd_d_addr(cmd_d_addr), .cmd_wdata(cmd_wdata), .cmd_last(cmd_last),
        .wready(wready), .wr_match(wr_match), .s_addr(s_addr), .d_addr(d_addr),
        .wdata(wdata), .rdata(rdata), .ising_rstn(ising_rstn), .busy(busy),
        .done(done), .err(err), .err_count(err_count)
    );

    typedef struct {
        logic [15:0] s;
        logic [15:0] d;
        logic [31:0] w;
        bit          c;
    } wr_t;

    typedef struct {
        int nw;
        int settle;
        int run;
        bit err;
        int ecnt;
    } batch_t;

    wr_t    exp_q[$];
    batch_t exp_b[$];
    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    bit     cur_corrupt = 1'b0;

    // Array readback: echoes the bus data unless the current write is marked corrupt.
    assign rdata = cur_corrupt ? 32'hAAAAAAAA : wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops writes and batch results as the DUT presents them.
    int  prev_acc = -1, last_acc = 0, last_wm = 0, rise = 0, nb = 0;
    bit  vdrop = 1'b0, prev_wready = 1'b0, prev_rstn = 1'b0, prev_done = 1'b0;
    wr_t last_w;
    always @(negedge clk) begin
        if (axi_rst) begin
            prev_acc = -1;
            prev_wready = 1'b0; prev_rstn = 1'b0; prev_done = 1'b0;
        end else begin
            if (start && !abort && !busy) begin
                nb = 0; prev_acc = -1; vdrop = 1'b0;
            end
            if (cmd_valid && cmd_ready && !abort) begin
                if (prev_acc >= 0 && !vdrop) chk("accept_spacing", cyc - prev_acc, RB ? 3 : 2);
                prev_acc = cyc; last_acc = cyc; vdrop = 1'b0;
            end else if (!cmd_valid) begin
                vdrop = 1'b1;
            end
            if (wready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wready: got pulse expected none (cycle %0d)", cyc);
                end else begin
                    last_w = exp_q.pop_front();
                    chk("s_addr", s_addr, last_w.s);
                    chk("d_addr", d_addr, last_w.d);
                    chk("wdata", wdata, last_w.w);
                    chk("wr_latency", cyc - last_acc, 1);
                    chk("wr_match_in_write", wr_match, 1'b1);
                    cur_corrupt = last_w.c;
                    nb++;
                end
            end else if (wr_match) begin
                checks++;
                if (!RB || !prev_wready) begin
                    errors++;
                    $display("FAIL verify_cycle: got wr_match without write expected none (cycle %0d)", cyc);
                end
                chk("verify_addr_hold", {s_addr, d_addr, wdata}, {last_w.s, last_w.d, last_w.w});
            end
            if (wr_match) last_wm = cyc;
            if (ising_rstn && !prev_rstn) rise = cyc;
            if (done && !prev_done) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done expected none (cycle %0d)", cyc);
                end else begin
                    batch_t b;
                    b = exp_b.pop_front();
                    chk("batch_writes", nb, b.nw);
                    chk("settle_len", rise - last_wm - 1, b.settle);
                    chk("run_len", cyc - rise, b.run);
                    chk("err", err, b.err);
                    chk("err_count", err_count, b.ecnt);
                end
            end
            prev_wready = wready; prev_rstn = ising_rstn; prev_done = done;
        end
    end

    // cmode: 0 none, 1 second write only, 2 all, 3 random
    task automatic run_batch(input int n, input int rl, input bit gaps, input int cmode, input bit abort_run);
        wr_t    cmds[$];
        batch_t b;
        int     mism = 0;
        int     budget;
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.s = 16'($urandom); e.d = 16'($urandom); e.w = $urandom;
            e.c = (cmode == 2) || (cmode == 1 && i == 1) || (cmode == 3 && $urandom_range(0, 2) == 0);
            if (e.c && e.w == 32'hAAAAAAAA) e.w = 32'h12345678;
            if (RB && e.c) mism++;
            cmds.push_back(e);
            exp_q.push_back(e);
        end
        b.nw = n; b.settle = SETTLE; b.run = (rl == 0) ? 1 : rl;
        b.err = (mism > 0); b.ecnt = (mism > EMAX) ? EMAX : mism;
        if (!abort_run) exp_b.push_back(b);
        start = 1'b1; run_len = rl;
        tick();
        start = 1'b0;
        chk("done_cleared_on_start", done, 1'b0);
        chk("busy_in_load", busy, 1'b1);
        chk("rstn_low_in_load", ising_rstn, 1'b0);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin cmd_valid = 1'b0; tick(); end
            end
            cmd_valid = 1'b1; cmd_s_addr = cmds[i].s; cmd_d_addr = cmds[i].d;
            cmd_wdata = cmds[i].w; cmd_last = (i == n - 1);
            budget = 0;
            while (!cmd_ready && budget < 20) begin tick(); budget++; end
            if (!cmd_ready) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no cmd_ready expected ready within 20 cycles");
            end
            tick();
        end
        cmd_valid = 1'b0; cmd_last = 1'b0;
        budget = 0;
        if (abort_run) begin
            while (!ising_rstn && budget < SETTLE + 20) begin tick(); budget++; end
            repeat (3) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_run_rstn", ising_rstn, 1'b0);
            chk("abort_run_busy", busy, 1'b0);
            chk("abort_run_done", done, 1'b0);
        end else begin
            while (!done && budget < rl + SETTLE + 40) begin tick(); budget++; end
            if (!done) begin
                checks++; errors++;
                $display("FAIL done_timeout: got done=0 expected done=1");
            end
        end
        repeat (2) tick();
    endtask

    initial begin
        axi_rst = 1'b1; start = 1'b0; abort = 1'b0; run_len = '0;
        cmd_valid = 1'b0; cmd_last = 1'b0; cmd_s_addr = '0; cmd_d_addr = '0; cmd_wdata = '0;
        repeat (3) tick();
        chk("rst_rstn", ising_rstn, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_wr_match", wr_match, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", {err, err_count}, '0);
        chk("rst_bus", {s_addr, d_addr, wdata}, '0);
        axi_rst = 1'b0;
        tick();

        run_batch(3, 5, 1'b0, 0, 1'b0);
        run_batch(3, 3, 1'b0, 1, 1'b0);
        run_batch(1, 100, 1'b0, 0, 1'b0);
        run_batch(2, 0, 1'b0, 0, 1'b0);

        // abort together with a command in LOAD
        start = 1'b1; run_len = 32'd10; tick(); start = 1'b0;
        cmd_valid = 1'b1; cmd_last = 1'b1; abort = 1'b1; cmd_wdata = 32'hDEAD0001;
        tick();
        cmd_valid = 1'b0; abort = 1'b0;
        chk("abort_load_wready", wready, 1'b0);
        chk("abort_load_idle", {busy, cmd_ready, done}, 3'b000);
        chk("abort_load_rstn", ising_rstn, 1'b0);
        tick();
        chk("abort_load_no_late_write", wr_match, 1'b0);

        // reset while a command is offered in LOAD
        start = 1'b1; tick(); start = 1'b0;
        cmd_valid = 1'b1; cmd_wdata = 32'hDEAD0002; axi_rst = 1'b1;
        tick();
        cmd_valid = 1'b0; axi_rst = 1'b0;
        chk("rst_mid_wready", wready, 1'b0);
        chk("rst_mid_state", {busy, cmd_ready, ising_rstn}, 3'b000);
        chk("rst_mid_bus", {s_addr, d_addr, wdata}, '0);
        tick();
        chk("rst_mid_no_late_write", wr_match, 1'b0);

        run_batch(2, 50, 1'b0, 0, 1'b1);

        for (int k = 0; k < 8; k++)
            run_batch($urandom_range(1, 6), $urandom_range(0, 30), 1'b1, 3, 1'b0);

        run_batch(EMAX + 2, 2, 1'b0, 2, 1'b0);

        chk("writes_drained", exp_q.size(), 0);
        chk("batches_drained", exp_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/coupling_prog_ctrl.md
COUPLING_PROG_CTRL -- requirements
Module: coupling_prog_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16, meaning cycles between the last weight write and ising_rstn release (legal range 1..255).
REQ-002 SHALL have parameter ERR_W, default 8, meaning width of the mismatch counter.
REQ-003 SHALL have one clock and a synchronous, active-high reset; reset is sampled on the rising edge of clk.
REQ-004 SHALL have port clk  input  1  system/AXI clock.
REQ-005 SHALL have port axi_rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports start  input  1  (begin programming) and abort  input  1  (return to IDLE).
REQ-007 SHALL have port run_len  input  32  annealing run length in cycles, sampled at start.
REQ-008 SHALL have ports cmd_valid  input  1, cmd_ready  output  1, cmd_s_addr  input  16, cmd_d_addr  input  16, cmd_wdata  input  32, and cmd_last  input  1 (final write of the batch).
REQ-009 SHALL have column-bus ports wready  output  1, wr_match  output  1, s_addr  output  16, d_addr  output  16, wdata  output  32, and rdata  input  32.
REQ-010 SHALL have ports ising_rstn  output  1 (array reset, low = held), busy  output  1, done  output  1, err  output  1, and err_count  output  ERR_W.

Function
REQ-011 SHALL implement states IDLE, LOAD, WRITE, VERIFY, SETTLE, RUN, and DONE.
REQ-012 SHALL transition IDLE->LOAD, and DONE->LOAD, on start; start SHALL be ignored in all other states.
REQ-013 SHALL, on entry to LOAD, latch run_len, clear err and err_count, and drive ising_rstn=0.
REQ-014 SHALL drive cmd_ready=1 only in LOAD; on cmd_valid&cmd_ready it SHALL register addr/data/last into s_addr/d_addr/wdata and go to WRITE.
REQ-015 SHALL, in WRITE, drive wready=1 and wr_match=1 for exactly one cycle, then go to VERIFY (readback enabled) or else to LOAD, or to SETTLE if last was set.
REQ-016 SHALL, in VERIFY, drive wr_match=1 and wready=0 for one cycle, compare rdata against the registered wdata in that cycle, then go to LOAD, or to SETTLE if last was set.
REQ-017 SHALL, on a VERIFY mismatch, set err (sticky until the next LOAD entry) and increment err_count, saturating at all-ones; programming SHALL continue.
REQ-018 SHALL hold s_addr/d_addr/wdata stable from WRITE through VERIFY; outside WRITE/VERIFY, wready=0 and wr_match=0.
REQ-019 SHALL, in SETTLE, hold ising_rstn=0 for exactly SETTLE_CYCLES cycles, then go to RUN.
REQ-020 SHALL, in RUN, drive ising_rstn=1 for max(run_len,1) cycles (32-bit down-counter, no wrap), then go to DONE.
REQ-021 SHALL, in DONE, keep ising_rstn=1 (the array state is held for readout) and assert done=1 until the next start or abort.
REQ-022 SHALL assert busy=1 in LOAD, WRITE, VERIFY, SETTLE, and RUN.
REQ-023 SHALL give an accept-to-bus latency of 1 cycle: a command accepted in cycle t appears as wready=1 in cycle t+1; the next accept occurs no earlier than t+3 (readback) or t+2 (no readback).
REQ-024 SHALL, on abort in any state, go to IDLE next cycle with ising_rstn=0, wready=0, wr_match=0, and cmd_ready=0; abort SHALL take priority over start and cmd handshakes in the same cycle.
REQ-025 SHALL produce a legal one-write batch from cmd_last=1 on the first command; cmd_valid SHALL be ignored outside LOAD.

Reset
REQ-026 SHALL, while axi_rst=1, force state IDLE, ising_rstn=0, cmd_ready=0, wready=0, wr_match=0, s_addr=0, d_addr=0, wdata=0, busy=0, done=0, err=0, err_count=0, and all counters=0.
REQ-027 SHALL treat reset asserted mid-batch as an abort; no partial bus cycle SHALL follow deassertion.

Configuration
REQ-028 SHALL, when macro COUPLING_READBACK_EN is defined, include the VERIFY state and mismatch logic.
REQ-029 SHALL, when COUPLING_READBACK_EN is undefined, never enter VERIFY, tie err=0 and err_count=0, and leave rdata unused.

Verification
REQ-030 SHALL cover: three commands (last on the third), rdata echoing wdata -> three wready pulses; accepts at t, t+3, and t+6; err=0.
REQ-031 SHALL cover: a readback build with rdata forced to 32'hAAAAAAAA on the second write -> err=1, err_count=1, batch completes, and done asserts.
REQ-032 SHALL cover: SETTLE_CYCLES=16, run_len=100 -> ising_rstn rises exactly 16 cycles after the last write or verify cycle, stays high 100 cycles, then done=1.
REQ-033 SHALL cover: run_len=0 -> exactly one RUN cycle, then DONE.
REQ-034 SHALL cover: abort asserted together with cmd_valid in LOAD -> no wready pulse, IDLE next cycle, ising_rstn=0.
REQ-035 SHALL cover: err_count driven to 255 mismatches with ERR_W=8, then one more mismatch -> err_count remains 255.
